// File: rtl/mrf_spi_master.sv
// SPI master for MRF24J40-class radio register access: short/long headers,
// programmable SCK divider, command handshake and a synchronised interrupt detector.
module mrf_spi_master #(
  parameter int CLK_DIV        = 2,
  parameter int SHORT_ADDR_W   = 6,
  parameter int LONG_ADDR_W    = 10,
  parameter int LONG_PAD       = 4,
  parameter int DATA_W         = 8,
  parameter int CS_GAP         = 2,
  parameter int INT_ACTIVE_LOW = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_long,
  input  logic                   cmd_write,
  input  logic [LONG_ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0]      cmd_wdata,
  output logic                   done,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   busy,
  output logic                   sck,
  output logic                   cs_n,
  output logic                   mosi,
  input  logic                   miso,
  input  logic                   intr,
  output logic                   intr_level,
  output logic                   intr_pulse
);

  localparam int SHORT_N  = SHORT_ADDR_W + 2 + DATA_W;
  localparam int LONG_N   = LONG_ADDR_W + 2 + LONG_PAD + DATA_W;
  localparam int FRAME_W  = (LONG_N > SHORT_N) ? LONG_N : SHORT_N;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W    = $clog2(FRAME_W);
  localparam int GAP_LAST = (CS_GAP > 2) ? CS_GAP - 2 : 0;
  localparam int GAP_W    = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic INT_INV = (INT_ACTIVE_LOW != 0);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP} state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bits_left;
  logic [GAP_W-1:0]    gap_cnt;
  logic [FRAME_W-1:0]  shreg;
  logic [FRAME_W-1:0]  frame;
  logic [DATA_W-1:0]   rx_shift;
  logic                is_read;
  logic [SHORT_N-1:0]  short_frame;
  logic [LONG_N-1:0]   long_frame;
  logic [DATA_W-1:0]   tx_data;
  logic                intr_meta;
  logic                intr_sync;

  // Both formats are left-aligned in the shift register so the MSB always leaves first.
  always_comb begin
    tx_data     = cmd_write ? cmd_wdata : '0;
    short_frame = {1'b0, cmd_addr[SHORT_ADDR_W-1:0], cmd_write, tx_data};
    long_frame  = '0;
    long_frame[LONG_N-1 -: LONG_ADDR_W+2] = {1'b1, cmd_addr, cmd_write};
    long_frame[DATA_W-1:0] = tx_data;
    if (cmd_long)
      frame = FRAME_W'(long_frame) << (FRAME_W - LONG_N);
    else
      frame = FRAME_W'(short_frame) << (FRAME_W - SHORT_N);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bits_left <= '0;
      gap_cnt   <= '0;
      shreg     <= '0;
      rx_shift  <= '0;
      is_read   <= 1'b0;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
      sck       <= 1'b0;
      cs_n      <= 1'b1;
      mosi      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            shreg     <= frame;
            mosi      <= frame[FRAME_W-1];
            bits_left <= cmd_long ? BIT_W'(LONG_N - 1) : BIT_W'(SHORT_N - 1);
            is_read   <= ~cmd_write;
            cs_n      <= 1'b0;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            div_cnt   <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sck     <= 1'b1;
            state   <= SHIFT_HI;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT_HI: begin
          if (div_cnt == '0)
            rx_shift <= {rx_shift[DATA_W-2:0], miso};
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sck     <= 1'b0;
            state   <= SHIFT_LO;
            if (bits_left != '0) begin
              shreg <= shreg << 1;
              mosi  <= shreg[FRAME_W-2];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT_LO: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (bits_left == '0) begin
              state <= HOLD;
              cs_n  <= 1'b1;
              mosi  <= 1'b0;
              done  <= 1'b1;
              if (is_read)
                rsp_rdata <= rx_shift;
            end else begin
              bits_left <= bits_left - 1'b1;
              sck       <= 1'b1;
              state     <= SHIFT_HI;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        // HOLD already counts as the first cs_n-high cycle after the frame.
        HOLD: begin
          gap_cnt <= '0;
          if (CS_GAP <= 1) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            state <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(GAP_LAST)) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Polarity is folded in before the synchroniser so cleared flops mean "inactive".
  always_ff @(posedge clk) begin
    if (rst) begin
      intr_meta  <= 1'b0;
      intr_sync  <= 1'b0;
      intr_level <= 1'b0;
      intr_pulse <= 1'b0;
    end else begin
      intr_meta  <= intr ^ INT_INV;
      intr_sync  <= intr_meta;
      intr_level <= intr_sync;
      intr_pulse <= intr_sync & ~intr_level;
    end
  end

endmodule

// File: tb/tb_mrf_spi_master.sv
// Bench for mrf_spi_master: one default instance and one CLK_DIV=1 instance,
// a clocked radio model, a vector table and a few multi-cycle sequences.
module tb_mrf_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       cmd_valid;
  logic       cmd_long;
  logic       cmd_write;
  logic [9:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       miso;
  logic       intr;
  logic       sel;

  logic       valid0, ready0, done0, busy0, sck0, cs_n0, mosi0, il0, ip0;
  logic       valid1, ready1, done1, busy1, sck1, cs_n1, mosi1, il1, ip1;
  logic [7:0] rdata0, rdata1;

  logic       m_ready, m_done, m_busy, m_sck, m_cs_n, m_mosi, m_il, m_ip;
  logic [7:0] m_rdata;

  assign valid0  = cmd_valid && !sel;
  assign valid1  = cmd_valid && sel;
  assign m_ready = sel ? ready1 : ready0;
  assign m_done  = sel ? done1  : done0;
  assign m_busy  = sel ? busy1  : busy0;
  assign m_sck   = sel ? sck1   : sck0;
  assign m_cs_n  = sel ? cs_n1  : cs_n0;
  assign m_mosi  = sel ? mosi1  : mosi0;
  assign m_il    = sel ? il1    : il0;
  assign m_ip    = sel ? ip1    : ip0;
  assign m_rdata = sel ? rdata1 : rdata0;

  mrf_spi_master dut0 (
    .clk(clk), .rst(rst), .cmd_valid(valid0), .cmd_ready(ready0),
    .cmd_long(cmd_long), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .done(done0), .rsp_rdata(rdata0), .busy(busy0),
    .sck(sck0), .cs_n(cs_n0), .mosi(mosi0), .miso(miso), .intr(intr),
    .intr_level(il0), .intr_pulse(ip0)
  );

  mrf_spi_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(valid1), .cmd_ready(ready1),
    .cmd_long(cmd_long), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .done(done1), .rsp_rdata(rdata1), .busy(busy1),
    .sck(sck1), .cs_n(cs_n1), .mosi(mosi1), .miso(miso), .intr(intr),
    .intr_level(il1), .intr_pulse(ip1)
  );

  int errors = 0;
  int checks = 0;

  // Radio model: captures mosi on sck rise, shifts miso after sck fall.
  int          exp_n_cur = 16;
  logic [31:0] miso_word = '0;
  logic        cs_prev   = 1'b1;
  logic        sck_prev  = 1'b0;
  int          miso_idx  = -1;
  int          pulse_cnt = 0;
  logic [31:0] mosi_cap  = '0;

  always @(posedge clk) begin
    cs_prev  <= m_cs_n;
    sck_prev <= m_sck;
    if (!m_cs_n && cs_prev) begin
      miso_idx  <= exp_n_cur - 1;
      pulse_cnt <= 0;
      mosi_cap  <= '0;
    end else if (!m_cs_n) begin
      if (m_sck && !sck_prev) begin
        mosi_cap  <= {mosi_cap[30:0], m_mosi};
        pulse_cnt <= pulse_cnt + 1;
      end
      if (!m_sck && sck_prev)
        miso_idx <= miso_idx - 1;
    end
  end

  assign miso = (!m_cs_n && miso_idx >= 0 && miso_idx < 32) ? miso_word[miso_idx] : 1'b0;

  typedef struct {
    logic        sel;
    logic        lng;
    logic        wr;
    logic [9:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata_in;
    logic [31:0] exp_frame;
    int          exp_n;
    int          exp_done;
    int          exp_ready;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; t counts cycles from the accept cycle (t=0).
  task automatic applyStimulus(input vec_t v, input string tag);
    int t;
    int done_t;
    int csn_t;
    int ready_t;
    int done_cnt;
    logic [7:0] rd;
    sel       = v.sel;
    exp_n_cur = v.exp_n;
    miso_word = 32'(v.rdata_in);
    cmd_long  = v.lng;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    t = 0;
    while (!m_ready && t < 200) begin
      step();
      t++;
    end
    checkOutput({tag, " ready before accept"}, 32'(m_ready), 32'd1);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    cmd_long  = ~v.lng;
    cmd_write = ~v.wr;
    cmd_addr  = ~v.addr;
    cmd_wdata = ~v.wdata;
    t = 1;
    checkOutput({tag, " cs_n t1"}, 32'(m_cs_n), 32'd0);
    checkOutput({tag, " busy t1"}, 32'(m_busy), 32'd1);
    checkOutput({tag, " ready t1"}, 32'(m_ready), 32'd0);
    checkOutput({tag, " mosi t1"}, 32'(m_mosi), 32'(v.exp_frame[v.exp_n-1]));
    done_t = -1; csn_t = -1; ready_t = -1; done_cnt = 0; rd = '0;
    while (ready_t < 0 && t < 400) begin
      if (m_done) begin
        done_cnt++;
        if (done_t < 0) begin
          done_t = t;
          rd = m_rdata;
        end
      end
      if (m_cs_n && csn_t < 0) csn_t = t;
      if (m_ready) ready_t = t;
      if (ready_t < 0) begin
        step();
        t++;
      end
    end
    checkOutput({tag, " done time"}, 32'(done_t), 32'(v.exp_done));
    checkOutput({tag, " done count"}, 32'(done_cnt), 32'd1);
    checkOutput({tag, " cs_n high time"}, 32'(csn_t), 32'(v.exp_done));
    checkOutput({tag, " ready time"}, 32'(ready_t), 32'(v.exp_ready));
    checkOutput({tag, " rsp_rdata"}, 32'(rd), 32'(v.exp_rdata));
    checkOutput({tag, " mosi frame"}, mosi_cap, v.exp_frame);
    checkOutput({tag, " sck pulses"}, 32'(pulse_cnt), 32'(v.exp_n));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t iv;
    int lim;
    int gap;
    int dcount;

    vecs[0] = '{1'b0, 1'b0, 1'b1, 10'h018, 8'hA5, 8'h00, 32'h31A5,   16, 67, 69,  8'h00};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 10'h00A, 8'h00, 8'h3C, 32'h1400,   16, 67, 69,  8'h3C};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 10'h200, 8'h5A, 8'h00, 32'hC0105A, 24, 99, 101, 8'h3C};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 10'h30F, 8'h00, 8'h81, 32'hE1E000, 24, 50, 52,  8'h81};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 10'h005, 8'hFF, 8'h00, 32'h0BFF,   16, 34, 36,  8'h81};

    rst = 1'b1; cmd_valid = 1'b0; cmd_long = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; intr = 1'b1; sel = 1'b0;
    repeat (3) step();
    checkOutput("reset cmd_ready", 32'(ready0), 32'd1);
    checkOutput("reset done", 32'(done0), 32'd0);
    checkOutput("reset rsp_rdata", 32'(rdata0), 32'd0);
    checkOutput("reset busy", 32'(busy0), 32'd0);
    checkOutput("reset sck", 32'(sck0), 32'd0);
    checkOutput("reset cs_n", 32'(cs_n0), 32'd1);
    checkOutput("reset mosi", 32'(mosi0), 32'd0);
    checkOutput("reset cs_n div1", 32'(cs_n1), 32'd1);
    rst = 1'b0;
    repeat (4) step();
    checkOutput("idle intr_level", 32'(il0), 32'd0);
    checkOutput("idle intr_pulse", 32'(ip0), 32'd0);

    for (int i = 0; i < 5; i++)
      applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Interrupt asserted mid-frame must not disturb the transfer.
    iv = vecs[0];
    iv.exp_rdata = 8'h3C;
    fork
      applyStimulus(iv, "intr_wr");
      begin
        repeat (20) @(posedge clk);
        #1;
        intr = 1'b0;
        for (int k = 0; k < 2; k++) begin
          step();
          checkOutput("intr_pulse early", 32'(ip0), 32'd0);
        end
        step();
        checkOutput("intr_pulse at 3", 32'(ip0), 32'd1);
        checkOutput("intr_level at 3", 32'(il0), 32'd1);
        step();
        checkOutput("intr_pulse width", 32'(ip0), 32'd0);
        checkOutput("intr_level held", 32'(il0), 32'd1);
      end
    join
    intr = 1'b1;
    repeat (4) step();
    checkOutput("intr_level release", 32'(il0), 32'd0);

    // Back-to-back with cmd_valid held: cs_n must stay high CS_GAP+1 cycles.
    sel = 1'b0; exp_n_cur = 16; miso_word = '0;
    cmd_long = 1'b0; cmd_write = 1'b1; cmd_addr = 10'h018; cmd_wdata = 8'hA5;
    cmd_valid = 1'b1;
    lim = 0; gap = 0; dcount = 0;
    while (m_cs_n && lim < 50) begin step(); lim++; end
    while (!m_cs_n && lim < 200) begin step(); lim++; end
    while (m_cs_n && lim < 250) begin gap++; step(); lim++; end
    cmd_valid = 1'b0;
    checkOutput("b2b cs_n gap", 32'(gap), 32'd3);
    lim = 0;
    while (!m_done && lim < 200) begin step(); lim++; end
    if (m_done) dcount = 1;
    checkOutput("b2b second done", 32'(dcount), 32'd1);
    checkOutput("b2b second frame", mosi_cap, 32'h31A5);
    lim = 0;
    while (!m_ready && lim < 20) begin step(); lim++; end

    // Reset during a long read: frame aborts, no done pulse.
    sel = 1'b0; exp_n_cur = 24; miso_word = 32'h81;
    cmd_long = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h30F; cmd_wdata = 8'h00;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    dcount = 0;
    for (int t = 1; t < 20; t++) begin
      if (m_done) dcount++;
      step();
    end
    checkOutput("abort cs_n before reset", 32'(m_cs_n), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("abort cs_n", 32'(m_cs_n), 32'd1);
    checkOutput("abort sck", 32'(m_sck), 32'd0);
    checkOutput("abort mosi", 32'(m_mosi), 32'd0);
    checkOutput("abort cmd_ready", 32'(m_ready), 32'd1);
    checkOutput("abort busy", 32'(m_busy), 32'd0);
    for (int t = 0; t < 5; t++) begin
      if (m_done) dcount++;
      step();
    end
    checkOutput("abort no done", 32'(dcount), 32'd0);
    applyStimulus(vecs[1], "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mrf_spi_master.md
Name: mrf_spi_master

Overview:
- Parametrised SPI master for register access to the MRF24J40-class 802.15.4 transceiver in the LR_WPAN path.
- Supersedes the fixed-width, SCK-equals-clk RF access block with a programmable SCK divider, a valid/ready command handshake, and a parallel read-data response.
- Also adds configurable address/data widths and a synchronised interrupt edge detector that remains active during transfers.
- Sits between the MAC/control FSM and the radio SPI pins.

Parameters:
- CLK_DIV, 2, clk cycles per SCK half-period (>=1).
- SHORT_ADDR_W, 6, short-address field width.
- LONG_ADDR_W, 10, long-address field width.
- LONG_PAD, 4, zero bits after the R/W bit in a long header.
- DATA_W, 8, data field width.
- CS_GAP, 2, minimum clk cycles cs_n stays high between transactions.
- INT_ACTIVE_LOW, 1, polarity of the radio interrupt pin.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_long  in  1  1 = long address format, 0 = short address format.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  LONG_ADDR_W  register address; short format uses bits [SHORT_ADDR_W-1:0].
- cmd_wdata  in  DATA_W  write data.
- done  out  1  one-cycle pulse when a transaction completes.
- rsp_rdata  out  DATA_W  read data; valid from the done cycle of a read.
- busy  out  1  transaction in progress.
- sck  out  1  SPI clock; idles low (mode 0).
- cs_n  out  1  chip select, active low.
- mosi  out  1  serial data to the radio.
- miso  in  1  serial data from the radio.
- intr  in  1  radio interrupt pin.
- intr_level  out  1  synchronised interrupt, active high.
- intr_pulse  out  1  one-cycle pulse on the asserting edge of the interrupt.

Behaviour:
- Reset values: cmd_ready=1, done=0, rsp_rdata=0, busy=0, sck=0, cs_n=1, mosi=0, intr_level=0, intr_pulse=0, and the interrupt synchroniser flops are cleared.
- A command is accepted on any cycle where cmd_valid && cmd_ready. All cmd_* inputs are captured on that cycle; later changes are ignored.
- Header formats:
  - Short: {1'b0, addr[SHORT_ADDR_W-1:0], cmd_write}.
  - Long: {1'b1, addr[LONG_ADDR_W-1:0], cmd_write, LONG_PAD zeros}.
- Frame = header followed by DATA_W data bits, shifted MSB first.
  - N = SHORT_ADDR_W+2+DATA_W (16 at defaults) for short.
  - N = LONG_ADDR_W+2+LONG_PAD+DATA_W (24 at defaults) for long.
  - Data bits are cmd_wdata for writes and zeros for reads.
- State machine: IDLE -> SETUP -> SHIFT_HI <-> SHIFT_LO -> HOLD -> GAP -> IDLE. Timing relative to the accept cycle (t=0):
  - t=1: cs_n=0, busy=1, cmd_ready=0, mosi=frame bit N-1, sck=0. SETUP lasts CLK_DIV cycles.
  - Each bit is sent as CLK_DIV cycles with sck=1 (SHIFT_HI), then CLK_DIV cycles with sck=0 (SHIFT_LO).
  - miso is registered on the first clk of each SHIFT_HI phase.
  - mosi advances to the next bit on the first clk of each SHIFT_LO phase, except after the last bit, where mosi goes to 0 and the state is HOLD.
  - t=(2N+1)*CLK_DIV+1: cs_n=1, sck=0, done=1 for one cycle.
  - On a read, rsp_rdata is loaded with the last DATA_W miso samples (MSB first) on that same cycle.
  - On a write, rsp_rdata is unchanged.
  - GAP: cs_n held high for CS_GAP cycles, then cmd_ready=1 and busy=0.
- Back-to-back commands: cs_n is high for at least CS_GAP+1 cycles between frames. cmd_valid held high is accepted on the first cycle cmd_ready=1.
- Interrupt handling:
  - intr passes through a 2-flop synchroniser and is inverted if INT_ACTIVE_LOW.
  - intr_level is the synchronised, active-high value.
  - intr_pulse fires on a 0->1 transition of intr_level, 3 clk after the pin edge.
  - The interrupt never aborts or stalls a transaction. Interrupt edges during a frame are still reported.
- rst asserted mid-frame: on the next edge cs_n=1, sck=0, mosi=0, no done pulse is generated, and the block returns to IDLE with cmd_ready=1.
- CLK_DIV=1 is legal: sck toggles every clk, giving SCK = clk/2.

Test Plan:
- Short write, cmd_addr=0x18, cmd_wdata=0xA5, defaults -> mosi stream sampled on sck rising edges = 0x31A5; 16 sck pulses; done at t=67; cs_n high again at t=67; cmd_ready at t=69.
- Short read, cmd_addr=0x0A, radio model drives miso=0x3C during the data phase -> mosi header 0x14 then 0x00; rsp_rdata=0x3C on the done cycle.
- Long write, cmd_addr=0x200, cmd_wdata=0x5A -> mosi = 0xC0105A; 24 sck pulses; done at t=(49*2)+1=99.
- Long read, cmd_addr=0x30F, miso=0x81, CLK_DIV=1 -> header 0xE1E0; rsp_rdata=0x81; done at t=50; a following write leaves rsp_rdata=0x81.
- Reset at t=20 of a long read -> next cycle cs_n=1 and sck=0, no done pulse, cmd_ready=1; a new short read then completes normally.
- intr driven low (INT_ACTIVE_LOW=1) during the SHIFT phase of a short write -> intr_pulse one cycle 3 clk later; intr_level=1; frame bits and done timing unchanged.
